// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: requester count,
// FSM state encoding and the round-robin pick helper.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // On contention the requester that did not win last time is picked.
    function automatic logic rr_pick(input logic last);
        return ~last;
    endfunction

endpackage

// File: rtl/ram_arbiter_spram.sv
// Single-port RAM: one access per cycle, registered read, read-before-write.
// Contents are deliberately not reset.
module ram_arbiter_spram #(
    parameter int WORDS = 512,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic                     write,
    input  logic [WIDTH-1:0]         d_in,
    output logic [WIDTH-1:0]         d_out
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (write) begin
            mem[addr] <= d_in;
        end
        d_out <= mem[addr];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of one single-port RAM, with round-robin
// grant on contention and a per-requester lock that holds ownership.
//
// state | meaning
// IDLE  | no owner; single valid requester wins, contention is round-robin
// LOCK0 | requester 0 owns the RAM until it drops valid or clears lock
// LOCK1 | requester 1 owns the RAM until it drops valid or clears lock
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORDS = 512,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    input  logic [$clog2(WORDS)-1:0] req0_addr,
    input  logic                     req0_write,
    input  logic [WIDTH-1:0]         req0_wdata,
    input  logic                     req0_lock,
    output logic                     req0_ready,

    input  logic                     req1_valid,
    input  logic [$clog2(WORDS)-1:0] req1_addr,
    input  logic                     req1_write,
    input  logic [WIDTH-1:0]         req1_wdata,
    input  logic                     req1_lock,
    output logic                     req1_ready,

    output logic                     rsp0_valid,
    output logic [WIDTH-1:0]         rsp0_rdata,
    output logic                     rsp1_valid,
    output logic [WIDTH-1:0]         rsp1_rdata
);

    localparam int ADDR_W = $clog2(WORDS);

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic                 last_q;
    logic                 last_d;
    logic [NUM_REQ-1:0]   pend_q;

    logic [NUM_REQ-1:0]   valid;
    logic [NUM_REQ-1:0]   lock;
    logic [NUM_REQ-1:0]   wr;
    logic [NUM_REQ-1:0]   ready;
    logic [NUM_REQ-1:0]   accept;

    logic [ADDR_W-1:0]    ram_addr;
    logic                 ram_write;
    logic [WIDTH-1:0]     ram_wdata;
    logic [WIDTH-1:0]     ram_dout;

    assign valid = {req1_valid, req0_valid};
    assign lock  = {req1_lock,  req0_lock};
    assign wr    = {req1_write, req0_write};

    // Grants are held low for the whole time reset is asserted.
    always_comb begin
        ready = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (&valid) begin
                        ready[rr_pick(last_q)] = 1'b1;
                    end else begin
                        ready = valid;
                    end
                end
                LOCK0:   ready[0] = valid[0];
                LOCK1:   ready[1] = valid[1];
                default: ready = '0;
            endcase
        end
    end

    assign accept = valid & ready;

    assign ram_addr  = accept[1] ? req1_addr  : req0_addr;
    assign ram_wdata = accept[1] ? req1_wdata : req0_wdata;
    assign ram_write = |(accept & wr);

    // With no accept, a locked owner must have dropped valid, so ownership ends.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (accept[0]) begin
            last_d  = 1'b0;
            state_d = lock[0] ? LOCK0 : IDLE;
        end else if (accept[1]) begin
            last_d  = 1'b1;
            state_d = lock[1] ? LOCK1 : IDLE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pend_q  <= accept;
        end
    end

    ram_arbiter_spram #(
        .WORDS (WORDS),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .write (ram_write),
        .d_in  (ram_wdata),
        .d_out (ram_dout)
    );

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign rsp0_valid = pend_q[0];
    assign rsp1_valid = pend_q[1];
    assign rsp0_rdata = pend_q[0] ? ram_dout : '0;
    assign rsp1_rdata = pend_q[1] ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter;

    localparam int WORDS = 512;
    localparam int WIDTH = 8;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req0_write, req0_lock, req0_ready;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_wdata;
    logic             req1_valid, req1_write, req1_lock, req1_ready;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_wdata;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;

    ram_arbiter #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_write (req0_write),
        .req0_wdata (req0_wdata),
        .req0_lock  (req0_lock),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_write (req1_write),
        .req1_wdata (req1_wdata),
        .req1_lock  (req1_lock),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: owner of a lock (-1 none), last winner, memory image, pending responses.
    int             m_owner = -1;
    int             m_last  = 1;
    logic [7:0]     m_mem   [WORDS];
    bit             m_known [WORDS];
    bit   [1:0]     m_rv = 2'b00;
    bit   [1:0]     m_rk = 2'b00;
    logic [7:0]     m_rd    [2];

    always @(negedge clk) begin
        logic [1:0]    v;
        logic [1:0]    er;
        logic [AW-1:0] a;
        logic          any_acc;
        if (!rst_n) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_rsp0_valid", rsp0_valid, 0);
            check("rst_rsp1_valid", rsp1_valid, 0);
            check("rst_rsp0_rdata", rsp0_rdata, 0);
            check("rst_rsp1_rdata", rsp1_rdata, 0);
            m_owner = -1;
            m_last  = 1;
            m_rv    = 2'b00;
        end else begin
            v  = {req1_valid, req0_valid};
            er = 2'b00;
            if (m_owner >= 0)   er[m_owner] = v[m_owner];
            else if (v == 2'b11) er[1 - m_last] = 1'b1;
            else                er = v;
            check("ready0", req0_ready, er[0]);
            check("ready1", req1_ready, er[1]);
            check("rsp0_valid", rsp0_valid, m_rv[0]);
            check("rsp1_valid", rsp1_valid, m_rv[1]);
            if (!m_rv[0])     check("rsp0_rdata_idle", rsp0_rdata, 0);
            else if (m_rk[0]) check("rsp0_rdata", rsp0_rdata, m_rd[0]);
            if (!m_rv[1])     check("rsp1_rdata_idle", rsp1_rdata, 0);
            else if (m_rk[1]) check("rsp1_rdata", rsp1_rdata, m_rd[1]);

            m_rv    = 2'b00;
            any_acc = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (v[n] && er[n]) begin
                    any_acc = 1'b1;
                    a       = (n == 0) ? req0_addr : req1_addr;
                    m_rv[n] = 1'b1;
                    m_rd[n] = m_mem[a];
                    m_rk[n] = m_known[a];
                    if ((n == 0) ? req0_write : req1_write) begin
                        m_mem[a]   = (n == 0) ? req0_wdata : req1_wdata;
                        m_known[a] = 1'b1;
                    end
                    m_last  = n;
                    m_owner = ((n == 0) ? req0_lock : req1_lock) ? n : -1;
                end
            end
            if (!any_acc) m_owner = -1;
        end
    end

    logic             s_r0, s_r1, s_v0, s_v1;
    logic [WIDTH-1:0] s_d0, s_d1;

    // Outputs captured mid-cycle; responses seen here belong to the previous step's beat.
    task automatic step();
        @(negedge clk);
        #1;
        s_r0 = req0_ready;  s_r1 = req1_ready;
        s_v0 = rsp0_valid;  s_v1 = rsp1_valid;
        s_d0 = rsp0_rdata;  s_d1 = rsp1_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_write = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic set0(input logic v, input logic w, input logic l, input logic [AW-1:0] a, input logic [7:0] d);
        req0_valid = v; req0_write = w; req0_lock = l; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic w, input logic l, input logic [AW-1:0] a, input logic [7:0] d);
        req1_valid = v; req1_write = w; req1_lock = l; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention right after reset: grants alternate starting with req0.
        set0(1, 1, 0, 9'h020, 8'h01);
        set1(1, 1, 0, 9'h021, 8'h02);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant0", s_r0, (i % 2) == 0);
            check("rr_grant1", s_r1, (i % 2) == 1);
            if (i > 0) begin
                check("rr_rsp0", s_v0, ((i - 1) % 2) == 0);
                check("rr_rsp1", s_v1, ((i - 1) % 2) == 1);
            end
        end
        idle_inputs();
        step();
        check("rr_last_rsp1", s_v1, 1);

        // Fill memory so every later read has a known expected value.
        for (int a = 0; a < WORDS; a++) begin
            set0(1, 1, 0, a[AW-1:0], a[7:0] ^ 8'h5A);
            step();
        end
        idle_inputs();
        step();

        // Write then immediately read the same word.
        set0(1, 1, 0, 9'h010, 8'hA5);
        step();
        set0(1, 0, 0, 9'h010, 8'h00);
        step();
        check("wr_rsp_valid", s_v0, 1);
        check("wr_old_data", s_d0, 8'h4A);
        idle_inputs();
        step();
        check("rd_rsp_valid", s_v0, 1);
        check("rd_new_data", s_d0, 8'hA5);

        // Top word, read-before-write.
        set0(1, 1, 0, 9'h1FF, 8'h11);
        step();
        set0(1, 1, 0, 9'h1FF, 8'h3C);
        step();
        check("top_first_old", s_d0, 8'hA5);
        set0(1, 0, 0, 9'h1FF, 8'h00);
        step();
        check("top_rbw", s_d0, 8'h11);
        idle_inputs();
        step();
        check("top_readback", s_d0, 8'h3C);

        // Req1 holds a lock over three beats while req0 waits.
        set0(1, 0, 0, 9'h005, 8'h00);
        for (int i = 0; i < 4; i++) begin
            set1(1, 0, i < 3, 9'h006, 8'h00);
            step();
            check("lock1_blocks0", s_r0, 0);
            check("lock1_grant1", s_r1, 1);
        end
        set1(1, 0, 0, 9'h006, 8'h00);
        step();
        check("after_lock1_grant0", s_r0, 1);
        check("after_lock1_no1", s_r1, 0);

        // Req0 locks, then drops valid for one cycle.
        idle_inputs();
        set0(1, 0, 1, 9'h007, 8'h00);
        step();
        check("lock0_grant", s_r0, 1);
        set0(0, 0, 0, 9'h007, 8'h00);
        set1(1, 0, 0, 9'h008, 8'h00);
        step();
        check("lock0_drop_r0", s_r0, 0);
        check("lock0_drop_r1", s_r1, 0);
        set0(1, 0, 0, 9'h007, 8'h00);
        step();
        check("post_drop_grant1", s_r1, 1);
        check("post_drop_no0", s_r0, 0);
        idle_inputs();
        step();

        // Reset lands while a read response is pending.
        set0(1, 0, 0, 9'h010, 8'h00);
        step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        check("rst_drop_rsp", s_v0, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_r0", s_r0, 0);
        check("post_rst_v0", s_v0, 0);
        check("post_rst_d0", s_d0, 0);
        set0(1, 0, 0, 9'h010, 8'h00);
        set1(1, 0, 0, 9'h1FF, 8'h00);
        step();
        check("post_rst_contention0", s_r0, 1);
        check("post_rst_contention1", s_r1, 0);
        idle_inputs();
        step();
        check("ram_survives_reset", s_d0, 8'hA5);

        // Randomized traffic on a small address window to exercise hazards.
        for (int i = 0; i < 3000; i++) begin
            set0($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 9'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            set1($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 31)),
                 8'($urandom_range(0, 255)));
            step();
        end
        idle_inputs();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WORDS, default 512, number of RAM words.
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid  input  1  requester N (N=0,1) access request.
REQ-006 reqN_addr  input  $clog2(WORDS)  requester N word address.
REQ-007 reqN_write  input  1  1 = write, 0 = read.
REQ-008 reqN_wdata  input  WIDTH  requester N write data.
REQ-009 reqN_lock  input  1  keep ownership after this beat.
REQ-010 reqN_ready  output  1  combinational grant; a beat is accepted when reqN_valid and reqN_ready are both 1 on a posedge.
REQ-011 rspN_valid  output  1  one-cycle response pulse for requester N.
REQ-012 rspN_rdata  output  WIDTH  RAM word at the accepted address, valid only with rspN_valid.

Function
REQ-013 The block SHALL own one internal single-port RAM: one access per cycle, 1-cycle registered read, read-before-write (a write returns the old word).
REQ-014 States SHALL be IDLE, LOCK0 and LOCK1; a register last_q holds the index of the last accepted requester.
REQ-015 In IDLE with one valid requester, that requester SHALL get ready=1.
REQ-016 In IDLE with both valid, the requester != last_q SHALL get ready=1 (round-robin).
REQ-017 At most one reqN_ready SHALL be 1 in any cycle; ready SHALL never be 1 while that requester's valid is 0.
REQ-018 The accepted beat SHALL drive the RAM address/write/wdata combinationally in the acceptance cycle; with no beat accepted, RAM write enable SHALL be 0.
REQ-019 An accepted beat with lockN=1 SHALL move the FSM to LOCKN; with lockN=0 it SHALL move or stay in IDLE.
REQ-020 In LOCKN only requester N SHALL be granted; the other requester's ready SHALL be 0 even if it is valid.
REQ-021 In LOCKN with reqN_valid=0, no beat SHALL be accepted and the FSM SHALL return to IDLE on that edge.
REQ-022 Every accepted beat (read or write) SHALL produce rspN_valid=1 exactly one cycle later, with rspN_rdata = RAM output.
REQ-023 Back-to-back beats from one requester SHALL give back-to-back response pulses with no bubble.
REQ-024 rspN_rdata SHALL be all-zero whenever rspN_valid=0.
REQ-025 A read of an address written in the previous cycle SHALL return the new data.

Reset
REQ-026 While rst_n=0: FSM=IDLE, last_q=1 (requester 0 wins the first contention), all ready=0, all rsp_valid=0, all rsp_rdata=0.
REQ-027 A response pending when rst_n asserts SHALL be dropped; a RAM write on the same edge as reset assertion is not guaranteed.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-029 The state enum (IDLE/LOCK0/LOCK1) SHALL be in a shared package ram_arb_pkg; the requester count (2) SHALL be a package constant.
REQ-030 The RAM SHALL be a single sub-module instance of the team's existing single-port RAM (ports clk, addr, write, d_in, d_out), parameterised with WORDS/WIDTH.

Verification
REQ-031 Req0 writes 0xA5 @0x010, next cycle reads @0x010 -> rsp0_valid twice, second rsp0_rdata=0xA5.
REQ-032 Both valid every cycle in IDLE, lock=0 after reset -> grants alternate 0,1,0,1; each rsp on the correct port one cycle after its grant.
REQ-033 Req1 lock=1 for 3 beats then lock=0 while req0 held valid -> req0_ready=0 for those 4 beats, req0 granted on the 5th cycle.
REQ-034 In LOCK0 req0 drops valid for 1 cycle -> no accept that cycle, FSM to IDLE; req1 granted on the next cycle.
REQ-035 Write 0x3C @0x1FF over previous 0x11 -> rsp_rdata=0x11 (read-before-write); address 0x1FF (top word) accepted.
REQ-036 rst_n asserted the cycle after an accepted read -> no rsp_valid pulse; after release all outputs 0 and first contention goes to req0.
